// File: rtl/partial_product_adder.sv
// Serial shift-and-add accumulator: sums signed partial products, beat k weighted by 2^k.
// Optional macro PPA_BEAT_COUNT_EN exposes the internal beat counter as output beat_count.
module partial_product_adder #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [DATA_WIDTH-1:0]                partial_product,
   input  logic                                 partial_product_valid,
   output logic [2*DATA_WIDTH-1:0]              result,
   output logic                                 result_ready,
`ifdef PPA_BEAT_COUNT_EN
   output logic [$clog2(DATA_WIDTH+1)-1:0]      beat_count,
`endif
   output logic                                 overflow
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] MAX_BEATS = CW'(DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   state_t                  state;
   logic [CW-1:0]           count;
   logic [2*DATA_WIDTH-1:0] pp_ext;
   logic [2*DATA_WIDTH-1:0] pp_shifted;

   assign pp_ext     = {{DATA_WIDTH{partial_product[DATA_WIDTH-1]}}, partial_product};
   assign pp_shifted = pp_ext << count;

`ifdef PPA_BEAT_COUNT_EN
   assign beat_count = count;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         result       <= '0;
         result_ready <= 1'b0;
         overflow     <= 1'b0;
         count        <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // a beat here always opens a new frame: load, never add
               if (partial_product_valid) begin
                  result       <= pp_ext;
                  count        <= CW'(1);
                  overflow     <= 1'b0;
                  result_ready <= 1'b0;
                  state        <= ACCUM;
               end
            end
            ACCUM: begin
               if (partial_product_valid) begin
                  if (count == MAX_BEATS) begin
                     overflow <= 1'b1;
                  end else begin
                     result <= result + pp_shifted;
                     count  <= count + CW'(1);
                  end
               end else begin
                  result_ready <= 1'b1;
                  state        <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_partial_product_adder.sv
// Directed self-checking bench for partial_product_adder (DATA_WIDTH=16).
module tb_partial_product_adder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] partial_product;
   logic        partial_product_valid;
   logic [31:0] result;
   logic        result_ready;
   logic        overflow;
`ifdef PPA_BEAT_COUNT_EN
   logic [4:0]  beat_count;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   partial_product_adder #(.DATA_WIDTH(16)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .partial_product       (partial_product),
      .partial_product_valid (partial_product_valid),
      .result                (result),
      .result_ready          (result_ready),
`ifdef PPA_BEAT_COUNT_EN
      .beat_count            (beat_count),
`endif
      .overflow              (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // inputs change 1 time unit after the edge; outputs are sampled there too
   task automatic beat(input logic [15:0] pp);
      partial_product       = pp;
      partial_product_valid = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      partial_product_valid = 1'b0;
      partial_product       = 16'h0000;
      @(posedge clk); #1;
   endtask

   initial begin
      reset                 = 1'b1;
      partial_product       = 16'h0000;
      partial_product_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset_result", result, 32'h0);
      chk("reset_ready", {31'b0, result_ready}, 32'h0);
      chk("reset_ovf", {31'b0, overflow}, 32'h0);
`ifdef PPA_BEAT_COUNT_EN
      chk("reset_cnt", {27'b0, beat_count}, 32'd0);
`endif
      reset = 1'b0;

      // basic positive
      beat(16'h0100);
      chk("pos_b0", result, 32'h00000100);
      beat(16'h0200);
      chk("pos_b1", result, 32'h00000500);
      chk("pos_ready_low", {31'b0, result_ready}, 32'h0);
      idle();
      chk("pos_ready", {31'b0, result_ready}, 32'h1);
      chk("pos_result", result, 32'h00000500);
      chk("pos_ovf", {31'b0, overflow}, 32'h0);

      // signed frame after reset
      reset = 1'b1; idle(); reset = 1'b0;
      chk("sgn_reset", result, 32'h0);
      beat(16'h0800);
      beat(16'hFE00);
      chk("sgn_b1", result, 32'h00000400);
      beat(16'hFF00);
      beat(16'hFF80);
      idle();
      chk("sgn_result", result, 32'hFFFFFC00);
      chk("sgn_ready", {31'b0, result_ready}, 32'h1);
`ifdef PPA_BEAT_COUNT_EN
      chk("sgn_cnt", {27'b0, beat_count}, 32'd4);
`endif
      idle(); idle(); idle();
      chk("sgn_ready_hold", {31'b0, result_ready}, 32'h1);
      chk("sgn_result_hold", result, 32'hFFFFFC00);

      // back-to-back frames
      beat(16'h0003);
      idle();
      chk("b2b_f0", result, 32'h00000003);
      chk("b2b_f0_ready", {31'b0, result_ready}, 32'h1);
      beat(16'h0001);
      chk("b2b_ready_drop", {31'b0, result_ready}, 32'h0);
      chk("b2b_load", result, 32'h00000001);
      beat(16'h0001);
      chk("b2b_sum", result, 32'h00000003);
      idle();
      chk("b2b_ready", {31'b0, result_ready}, 32'h1);

      // overflow: 17 beats of 1
      for (int i = 0; i < 16; i++) beat(16'h0001);
      chk("ovf_16_result", result, 32'h0000FFFF);
      chk("ovf_16_flag", {31'b0, overflow}, 32'h0);
      beat(16'h0001);
      chk("ovf_17_flag", {31'b0, overflow}, 32'h1);
      chk("ovf_17_result", result, 32'h0000FFFF);
      idle();
      chk("ovf_ready", {31'b0, result_ready}, 32'h1);
      chk("ovf_sticky", {31'b0, overflow}, 32'h1);
`ifdef PPA_BEAT_COUNT_EN
      chk("ovf_cnt", {27'b0, beat_count}, 32'd16);
`endif
      beat(16'hFFFF);
      chk("ovf_clear", {31'b0, overflow}, 32'h0);
      chk("ovf_new_load", result, 32'hFFFFFFFF);
      idle();

      // reset mid-frame
      beat(16'h7FFF);
      beat(16'h7FFF);
      chk("rst_mid_sum", result, 32'h00017FFD);
      reset = 1'b1;
      beat(16'h7FFF);
      chk("rst_mid_result", result, 32'h0);
      chk("rst_mid_ready", {31'b0, result_ready}, 32'h0);
      chk("rst_mid_ovf", {31'b0, overflow}, 32'h0);
      beat(16'h7FFF);
      chk("rst_held", result, 32'h0);
      reset = 1'b0;
      beat(16'h0005);
      chk("rst_new_frame", result, 32'h00000005);
      beat(16'h0001);
      chk("rst_new_b1", result, 32'h00000007);
      idle();
      chk("rst_new_ready", {31'b0, result_ready}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
